moving_avg_decoder: RTL and testbench

//  Inverse of the 4-tap unity-weight moving-sum FIR stage: recovers x[n] from y[n]=x[n]+x[n-1]+x[n-2]+x[n-3].

---
 rtl/moving_avg_decoder.sv | 87 ++++++++
 tb/tb_moving_avg_decoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/moving_avg_decoder.sv
// Inverse of a 4-tap unity-weight moving sum: x[n] = y[n] - x[n-1] - x[n-2] - x[n-3].
// Single output register with valid/ready on both sides; sticky range error flags desync.
module moving_avg_decoder #(
  parameter int N     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N+1:0]     in_data,
  input  logic             resync,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             err,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic {RUN, ERR} state_t;

  state_t state_q, state_d;

  logic [N-1:0] x1, x2, x3;
  logic [N-1:0] h1, h2, h3;
  logic [N+2:0] diff;
  logic         acc;
  logic         oor;

  assign in_ready = !out_valid | out_ready;
  assign acc      = in_valid & in_ready;
  assign err      = (state_q == ERR);

  // resync decodes the same-cycle sample against zero history
  always_comb begin
    h1 = resync ? '0 : x1;
    h2 = resync ? '0 : x2;
    h3 = resync ? '0 : x3;
    diff = {1'b0, in_data}
         - {3'b000, h1}
         - {3'b000, h2}
         - {3'b000, h3};
    oor = |diff[N+2:N];
  end

  always_comb begin
    state_d = state_q;
    if (resync)
      state_d = RUN;
    if (acc && oor)
      state_d = ERR;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      out_valid  <= 1'b0;
      out_data   <= '0;
      x1         <= '0;
      x2         <= '0;
      x3         <= '0;
      sample_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        out_data  <= diff[N-1:0];
        out_valid <= 1'b1;
        x3        <= h2;
        x2        <= h1;
        x1        <= diff[N-1:0];
      end else begin
        if (out_ready)
          out_valid <= 1'b0;
        if (resync) begin
          x1 <= '0;
          x2 <= '0;
          x3 <= '0;
        end
      end
      if (resync)
        sample_cnt <= acc ? CNT_W'(1) : '0;
      else if (acc)
        sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_moving_avg_decoder.sv
// Directed bench for moving_avg_decoder: reset, streaming, stalls,
// desync error, resync, mid-stream reset and a stalled random stream.
module tb_moving_avg_decoder;

  localparam int N     = 16;
  localparam int CNT_W = 16;
  localparam int NS    = 40;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N+1:0]     in_data;
  logic             resync;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             err;
  logic [CNT_W-1:0] sample_cnt;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] xs [NS];
  logic [N+1:0] ys [NS];

  moving_avg_decoder #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .resync     (resync),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .err        (err),
    .sample_cnt (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("%s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [N+1:0] y);
    in_valid = 1'b1;
    in_data  = y;
    tick();
  endtask

  initial begin
    int pi;
    int ci;
    int cyc;
    logic [N-1:0] t1 [5];
    logic [N+1:0] ty [5];
    logic acc;
    logic xfer;

    ty = '{18'd10, 18'd30, 18'd60, 18'd100, 18'd140};
    t1 = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};

    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    resync = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(sample_cnt), 0);
    chk("rst_inready", 32'(in_ready), 1);
    rst = 1'b1;

    // T1
    for (int i = 0; i < 5; i++) begin
      send(ty[i]);
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_data", 32'(out_data), 32'(t1[i]));
    end
    in_valid = 1'b0;
    chk("t1_err", 32'(err), 0);
    chk("t1_cnt", 32'(sample_cnt), 5);
    tick();
    chk("t1_drain", 32'(out_valid), 0);

    // T2: history 50,40,30 -> x=60 (y=180), x=70 (y=220)
    send(18'd180);
    chk("t2_first", 32'(out_data), 60);
    out_ready = 1'b0;
    in_data   = 18'd220;
    #1;
    chk("t2_inready_lo", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_data", 32'(out_data), 60);
      chk("t2_hold_valid", 32'(out_valid), 1);
      chk("t2_hold_cnt", 32'(sample_cnt), 6);
    end
    out_ready = 1'b1;
    #1;
    chk("t2_inready_hi", 32'(in_ready), 1);
    tick();
    chk("t2_resume", 32'(out_data), 70);
    chk("t2_cnt", 32'(sample_cnt), 7);
    in_valid = 1'b0;
    tick();

    // T3
    rst = 1'b0; tick(); rst = 1'b1;
    send(18'd70000);
    chk("t3_data", 32'(out_data), 4464);
    chk("t3_err", 32'(err), 1);
    send(18'd100);
    chk("t3_data2", 32'(out_data), 61172);
    chk("t3_sticky", 32'(err), 1);

    // T4
    resync = 1'b1;
    send(18'd5);
    resync = 1'b0;
    chk("t4_data", 32'(out_data), 5);
    chk("t4_err", 32'(err), 0);
    chk("t4_cnt", 32'(sample_cnt), 1);
    send(18'd12);
    chk("t4_data2", 32'(out_data), 7);
    chk("t4_cnt2", 32'(sample_cnt), 2);

    // T5
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("t5_pending", 32'(out_valid), 1);
    rst = 1'b0;
    tick();
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_data", 32'(out_data), 0);
    chk("t5_cnt", 32'(sample_cnt), 0);
    rst = 1'b1;
    out_ready = 1'b1;
    send(18'd9);
    chk("t5_after", 32'(out_data), 9);
    in_valid = 1'b0;
    tick();

    // T6: reference 4-tap summer feeding the decoder
    for (int i = 0; i < NS; i++) begin
      xs[i] = N'($urandom);
      ys[i] = (N+2)'(xs[i]);
      for (int k = 1; k < 4; k++)
        if (i - k >= 0)
          ys[i] = ys[i] + (N+2)'(xs[i-k]);
    end
    rst = 1'b0; tick(); rst = 1'b1;
    pi = 0; ci = 0; cyc = 0;
    while (ci < NS && cyc < 2000) begin
      in_valid  = (pi < NS) && ($urandom_range(3) != 0);
      in_data   = (pi < NS) ? ys[pi] : '0;
      out_ready = ($urandom_range(3) != 0);
      #1;
      acc  = in_valid & in_ready;
      xfer = out_valid & out_ready;
      if (xfer) begin
        chk("t6_data", 32'(out_data), 32'(xs[ci]));
        ci++;
      end
      tick();
      if (acc) pi++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("t6_done", 32'(ci), NS);
    chk("t6_err", 32'(err), 0);
    chk("t6_cnt", 32'(sample_cnt), NS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
